// File: rtl/alu_unit_if.sv
// Operand/result bundle between a requester and alu_unit.
// The requester drives operands and opcode; the ALU returns registered results.
interface alu_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic [2:0]       aluc;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             out_valid;

  modport master (
    output in_valid, src1, src2, aluc,
    input  result, zero, overflow, out_valid
  );

  modport slave (
    input  in_valid, src1, src2, aluc,
    output result, zero, overflow, out_valid
  );
endinterface

// File: rtl/alu_unit.sv
// Registered 32-bit ALU: AND/OR/ADD/SUB/SLT with zero and signed-overflow flags.
// One-cycle latency; outputs hold when no operation is accepted.
module alu_unit #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_unit_if.slave   bus
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             a_msb, b_msb;
  logic             add_ovf, sub_ovf;
  logic             signed_lt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;

  assign a_msb = bus.src1[WIDTH-1];
  assign b_msb = bus.src2[WIDTH-1];
  assign sum   = bus.src1 + bus.src2;
  assign diff  = bus.src1 - bus.src2;

  assign add_ovf = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb);
  assign sub_ovf = (a_msb != b_msb) && (diff[WIDTH-1] != a_msb);

  // The sign of the difference is wrong exactly when the subtraction overflows.
  assign signed_lt = diff[WIDTH-1] ^ sub_ovf;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    unique case (bus.aluc)
      OP_AND: alu_res = bus.src1 & bus.src2;
      OP_OR:  alu_res = bus.src1 | bus.src2;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = add_ovf;
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = sub_ovf;
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, signed_lt};
      default: begin
        alu_res = '0;
        alu_ovf = 1'b0;
      end
    endcase
  end

  always_comb begin
    result_d    = result_q;
    zero_d      = zero_q;
    overflow_d  = overflow_q;
    out_valid_d = 1'b0;
    if (bus.in_valid) begin
      result_d    = alu_res;
      zero_d      = (alu_res == '0);
      overflow_d  = alu_ovf;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      zero_q      <= 1'b1;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = overflow_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: expected results are queued at drive time
// and compared one edge later against a 64-bit signed behavioural model.
module tb_alu_unit;

  logic clk;
  logic rst_n;

  alu_unit_if #(.WIDTH(32)) bus ();

  alu_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    logic        vld;
  } exp_t;

  exp_t q[$];
  exp_t last_exp;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    exp_t   e;
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.tag = "";
    e.res = 32'd0;
    e.ovf = 1'b0;
    e.vld = 1'b1;
    case (op)
      3'b000: e.res = a & b;
      3'b001: e.res = a | b;
      3'b010: begin
        s     = sa + sb;
        e.res = s[31:0];
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'b110: begin
        s     = sa - sb;
        e.res = s[31:0];
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'b111: e.res = (sa < sb) ? 32'd1 : 32'd0;
      default: e.res = 32'd0;
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  task automatic drive_op(input string tag, input logic v, input logic [31:0] a,
                          input logic [31:0] b, input logic [2:0] op);
    exp_t e;
    @(negedge clk);
    bus.in_valid = v;
    bus.src1     = a;
    bus.src2     = b;
    bus.aluc     = op;
    if (v) begin
      e        = model(a, b, op);
      last_exp = e;
    end else begin
      e     = last_exp;
      e.vld = 1'b0;
    end
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_res"},  bus.result, 32'd0);
    chk({tag, "_zero"}, {31'd0, bus.zero}, 32'd1);
    chk({tag, "_ovf"},  {31'd0, bus.overflow}, 32'd0);
    chk({tag, "_vld"},  {31'd0, bus.out_valid}, 32'd0);
  endtask

  // Monitor: compare one queued expectation per edge, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.tag, "_res"},  bus.result, e.res);
        chk({e.tag, "_zero"}, {31'd0, bus.zero}, {31'd0, e.zero});
        chk({e.tag, "_ovf"},  {31'd0, bus.overflow}, {31'd0, e.ovf});
        chk({e.tag, "_vld"},  {31'd0, bus.out_valid}, {31'd0, e.vld});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] ops [5];
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b110; ops[4] = 3'b111;

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.src1     = '0;
    bus.src2     = '0;
    bus.aluc     = '0;
    last_exp     = '{tag: "", res: 32'd0, zero: 1'b1, ovf: 1'b0, vld: 1'b0};
    #13;
    check_reset("rst_init");
    @(negedge clk);
    rst_n = 1'b1;

    drive_op("and_f0",   1'b1, 32'h0000_00F0, 32'h0000_0FF0, 3'b000);
    drive_op("or_ff0",   1'b1, 32'h0000_00F0, 32'h0000_0FF0, 3'b001);
    drive_op("and_zero", 1'b1, 32'h0000_000F, 32'h0000_00F0, 3'b000);
    drive_op("add_95",   1'b1, 32'd37, 32'd58, 3'b010);
    drive_op("sub_eq",   1'b1, 32'd42, 32'd42, 3'b110);
    drive_op("sub_neg",  1'b1, 32'd3, 32'd5, 3'b110);
    drive_op("add_ovf",  1'b1, 32'h7FFF_FFFF, 32'd1, 3'b010);
    drive_op("sub_ovf",  1'b1, 32'h8000_0000, 32'd1, 3'b110);
    drive_op("slt_lt",   1'b1, 32'd12, 32'd99, 3'b111);
    drive_op("slt_gt",   1'b1, 32'd99, 32'd12, 3'b111);
    drive_op("slt_m1",   1'b1, 32'hFFFF_FFFF, 32'd0, 3'b111);
    drive_op("slt_min",  1'b1, 32'h8000_0000, 32'd1, 3'b111);
    drive_op("slt_eq",   1'b1, 32'd77, 32'd77, 3'b111);
    drive_op("add_1p1",  1'b1, 32'd1, 32'd1, 3'b010);
    drive_op("hold",     1'b0, 32'd500, 32'd600, 3'b010);
    drive_op("hold2",    1'b0, 32'd7, 32'd9, 3'b001);
    drive_op("unused",   1'b1, 32'h1234_5678, 32'h0000_FFFF, 3'b100);
    drive_op("ovf_clr",  1'b1, 32'h7FFF_FFFF, 32'd1, 3'b010);
    drive_op("ovf_or",   1'b1, 32'h7FFF_FFFF, 32'd1, 3'b001);

    // Reset mid-cycle while a result is being presented.
    drive_op("pre_rst",  1'b1, 32'd10, 32'd20, 3'b010);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset("rst_mid");
    q.delete();
    last_exp = '{tag: "", res: 32'd0, zero: 1'b1, ovf: 1'b0, vld: 1'b0};
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_reset("rst_held");
    @(negedge clk);
    rst_n = 1'b1;

    drive_op("post_rst", 1'b1, 32'd4, 32'd6, 3'b010);

    for (int i = 0; i < 255; i++) begin
      drive_op($sformatf("rnd%0d", i), 1'b1, 32'($urandom_range(99)),
               32'($urandom_range(99)), ops[$urandom_range(4)]);
    end

    drive_op("idle0", 1'b0, 32'd0, 32'd0, 3'b000);
    drive_op("idle1", 1'b0, 32'd0, 32'd0, 3'b000);
    @(posedge clk);
    #2;
    chk("drain", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
